// File: rtl/mage_stream_cfg_decoder.sv
// rtl/mage_stream_cfg_decoder.sv - stream/AGE configuration decoder with shadow/active banks
//
// Accepts flat configuration words one at a time, checks each word for
// legality and writes legal words into a shadow bank indexed by AGE entry.
// A commit copies the whole shadow bank into the active bank once the
// accelerator is idle, so the accelerator never sees a partly updated
// configuration.
//
// Ports:
//   clk_i          - clock, all state changes on the rising edge
//   rst_i          - asynchronous active-high reset
//   cfg_valid_i    - a configuration word is offered
//   cfg_ready_o    - the block can accept a word (FSM idle)
//   cfg_age_i      - target entry index of the offered word
//   cfg_word_i     - flat configuration word
//   cfg_clear_i    - pulse: drop the valid bit of every shadow entry
//   cfg_commit_i   - pulse: request a shadow-to-active copy
//   acc_busy_i     - accelerator running, active bank must stay frozen
//   active_cfg_o   - active words, entry k at [k*NBIT_WORD +: NBIT_WORD]
//   active_valid_o - valid bit (bit 24) of each active entry
//   commit_done_o  - one-cycle pulse when a commit has been applied
//   err_o          - one-cycle pulse when a word is rejected
//   err_age_o      - entry index of the last rejected word
//   err_code_o     - cause of the last rejection
//
// Word layout (LSB first):
//   [3:0]   hwlp_rf_sel
//   [5:4]   n_banks (count - 1)
//   [8:6]   bank_start
//   [10:9]  block_size
//   [11]    lns
//   [14:12] iv_constraint_sel
//   [15]    is_acc_store
//   [23:16] iv_const
//   [24]    valid
//
// Rejection codes, first failing check wins:
//   01 iv_constraint_sel > 4
//   10 banks run past bank 7
//   11 accumulator store without lns

module mage_stream_cfg_decoder #(
  parameter int N_AGE     = 8,
  parameter int NBIT_WORD = 25
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [$clog2(N_AGE)-1:0]   cfg_age_i,
  input  logic [NBIT_WORD-1:0]       cfg_word_i,
  input  logic                       cfg_clear_i,
  input  logic                       cfg_commit_i,
  input  logic                       acc_busy_i,
  output logic [N_AGE*NBIT_WORD-1:0] active_cfg_o,
  output logic [N_AGE-1:0]           active_valid_o,
  output logic                       commit_done_o,
  output logic                       err_o,
  output logic [$clog2(N_AGE)-1:0]   err_age_o,
  output logic [1:0]                 err_code_o
);

  localparam int AW        = $clog2(N_AGE);
  localparam int VALID_BIT = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_COMMIT_WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  // Word captured on the handshake; evaluated during CHECK.
  logic [AW-1:0]        lat_age;
  logic [NBIT_WORD-1:0] lat_word;

  // Commit requested together with a word: serviced right after CHECK.
  logic pending;

  logic [NBIT_WORD-1:0] shadow [N_AGE];
  logic [NBIT_WORD-1:0] active [N_AGE];

  // Control strobes produced by the next-state logic.
  logic accept;
  logic clear_en;
  logic write_en;
  logic reject_en;
  logic commit_en;
  logic pend_set;
  logic pend_clr;

  // Field decode of the latched word, only the fields the checks need.
  logic [1:0] f_n_banks;
  logic [2:0] f_bank_start;
  logic       f_lns;
  logic [2:0] f_iv_sel;
  logic       f_acc_store;

  assign f_n_banks    = lat_word[5:4];
  assign f_bank_start = lat_word[8:6];
  assign f_lns        = lat_word[11];
  assign f_iv_sel     = lat_word[14:12];
  assign f_acc_store  = lat_word[15];

  // One past the last bank used; n_banks holds count-1, hence the +1.
  // Four bits are enough for 7 + 3 + 1, so nothing wraps.
  logic [3:0] bank_end;
  assign bank_end = {1'b0, f_bank_start} + {2'b00, f_n_banks} + 4'd1;

  logic [1:0] chk_code;

  always_comb begin
    chk_code = 2'b00;
    if (f_iv_sel > 3'd4) begin
      chk_code = 2'b01;
    end else if (bank_end > 4'd8) begin
      chk_code = 2'b10;
    end else if (f_acc_store && !f_lns) begin
      chk_code = 2'b11;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    clear_en  = 1'b0;
    write_en  = 1'b0;
    reject_en = 1'b0;
    commit_en = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;

    case (state)
      ST_IDLE: begin
        // Clear lands at this edge; a word accepted in the same cycle is
        // written a cycle later from CHECK, so it survives the clear.
        clear_en = cfg_clear_i;
        if (cfg_valid_i) begin
          accept   = 1'b1;
          pend_set = cfg_commit_i;
          state_nx = ST_CHECK;
        end else if (cfg_commit_i) begin
          state_nx = ST_COMMIT_WAIT;
        end
      end

      ST_CHECK: begin
        if (chk_code == 2'b00) begin
          write_en = 1'b1;
        end else begin
          reject_en = 1'b1;
        end
        pend_clr = 1'b1;
        state_nx = pending ? ST_COMMIT_WAIT : ST_IDLE;
      end

      ST_COMMIT_WAIT: begin
        // Active bank stays frozen until the accelerator goes idle.
        if (!acc_busy_i) begin
          commit_en = 1'b1;
          state_nx  = ST_IDLE;
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign cfg_ready_o = (state == ST_IDLE);

  // ---------------------------------------------------------------------
  // Handshake capture and pending commit
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_age  <= '0;
      lat_word <= '0;
      pending  <= 1'b0;
    end else begin
      if (accept) begin
        lat_age  <= cfg_age_i;
        lat_word <= cfg_word_i;
      end
      if (pend_set) begin
        pending <= 1'b1;
      end else if (pend_clr) begin
        pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shadow bank: clear (IDLE) and write (CHECK) never coincide
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_AGE; k++) begin
        shadow[k] <= '0;
      end
    end else if (clear_en) begin
      for (int k = 0; k < N_AGE; k++) begin
        shadow[k][VALID_BIT] <= 1'b0;
      end
    end else if (write_en) begin
      shadow[lat_age] <= lat_word;
    end
  end

  // ---------------------------------------------------------------------
  // Active bank: only ever changes on a commit edge
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_AGE; k++) begin
        active[k] <= '0;
      end
    end else if (commit_en) begin
      for (int k = 0; k < N_AGE; k++) begin
        active[k] <= shadow[k];
      end
    end
  end

  for (genvar k = 0; k < N_AGE; k++) begin : g_out
    assign active_cfg_o[k*NBIT_WORD +: NBIT_WORD] = active[k];
    assign active_valid_o[k]                      = active[k][VALID_BIT];
  end

  // ---------------------------------------------------------------------
  // Status pulses and sticky error detail
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commit_done_o <= 1'b0;
      err_o         <= 1'b0;
      err_age_o     <= '0;
      err_code_o    <= 2'b00;
    end else begin
      commit_done_o <= commit_en;
      err_o         <= reject_en;
      if (reject_en) begin
        err_age_o  <= lat_age;
        err_code_o <= chk_code;
      end
    end
  end

endmodule

// File: tb/tb_mage_stream_cfg_decoder.sv
// tb/tb_mage_stream_cfg_decoder.sv - randomized self-checking bench for mage_stream_cfg_decoder

module tb_mage_stream_cfg_decoder;

  localparam int NA = 8;
  localparam int NW = 25;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [2:0]    cfg_age_i;
  logic [NW-1:0] cfg_word_i;
  logic          cfg_clear_i;
  logic          cfg_commit_i;
  logic          acc_busy_i;
  logic [NA*NW-1:0] active_cfg_o;
  logic [NA-1:0] active_valid_o;
  logic          commit_done_o;
  logic          err_o;
  logic [2:0]    err_age_o;
  logic [1:0]    err_code_o;

  mage_stream_cfg_decoder #(.N_AGE(NA), .NBIT_WORD(NW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_age_i     (cfg_age_i),
    .cfg_word_i    (cfg_word_i),
    .cfg_clear_i   (cfg_clear_i),
    .cfg_commit_i  (cfg_commit_i),
    .acc_busy_i    (acc_busy_i),
    .active_cfg_o  (active_cfg_o),
    .active_valid_o(active_valid_o),
    .commit_done_o (commit_done_o),
    .err_o         (err_o),
    .err_age_o     (err_age_o),
    .err_code_o    (err_code_o)
  );

  always #5 clk = ~clk;

  // Transaction-level model of what the outputs must be.
  logic [NW-1:0] m_shadow [NA];
  logic [NW-1:0] m_active [NA];
  logic          exp_ready;
  logic          exp_done;
  logic          exp_err;
  logic [2:0]    exp_err_age;
  logic [1:0]    exp_err_code;

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  logic [NA*NW-1:0] exp_flat;
  logic [NA-1:0]    exp_vb;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Legality from the word-format rules, with n_banks taken as a bank count.
  function automatic logic [1:0] legal_code(input logic [NW-1:0] w);
    int ivs;
    int nbanks;
    int bstart;
    ivs    = int'(w[14:12]);
    nbanks = int'(w[5:4]) + 1;
    bstart = int'(w[8:6]);
    if (ivs > 4) return 2'd1;
    if (bstart + nbanks > 8) return 2'd2;
    if (w[15] && !w[11]) return 2'd3;
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < NA; k++) begin
        exp_flat[k*NW +: NW] = m_active[k];
        exp_vb[k]            = m_active[k][24];
      end
      chk("active_cfg", active_cfg_o, exp_flat);
      chk("active_valid", active_valid_o, exp_vb);
      chk("cfg_ready", cfg_ready_o, exp_ready);
      chk("commit_done", commit_done_o, exp_done);
      chk("err", err_o, exp_err);
      chk("err_age", err_age_o, exp_err_age);
      chk("err_code", err_code_o, exp_err_code);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NA; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    exp_ready    = 1'b1;
    exp_done     = 1'b0;
    exp_err      = 1'b0;
    exp_err_age  = '0;
    exp_err_code = '0;
  endtask

  task automatic clear_shadow_valid();
    for (int k = 0; k < NA; k++) m_shadow[k][24] = 1'b0;
  endtask

  task automatic idle_inputs();
    cfg_valid_i  = 1'b0;
    cfg_clear_i  = 1'b0;
    cfg_commit_i = 1'b0;
    acc_busy_i   = 1'($urandom_range(0, 1));
    cfg_age_i    = 3'($urandom);
    cfg_word_i   = NW'($urandom);
  endtask

  // Noise on the request pins while the FSM is not idle; all of it must be ignored.
  task automatic junk();
    cfg_valid_i  = 1'($urandom_range(0, 1));
    cfg_clear_i  = 1'($urandom_range(0, 1));
    cfg_commit_i = 1'($urandom_range(0, 1));
    cfg_age_i    = 3'($urandom);
    cfg_word_i   = NW'($urandom);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    model_reset();
    idle_inputs();
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Entered one cycle into the commit wait.
  task automatic wait_commit(input int busy_n, input bit abort);
    for (int i = 0; i < busy_n; i++) begin
      junk();
      acc_busy_i = 1'b1;
      tick();
    end
    if (abort) begin
      do_reset();
      return;
    end
    junk();
    acc_busy_i = 1'b0;
    tick();
    for (int k = 0; k < NA; k++) m_active[k] = m_shadow[k];
    exp_done  = 1'b1;
    exp_ready = 1'b1;
    idle_inputs();
  endtask

  task automatic send_word(input logic [2:0] age, input logic [NW-1:0] w, input bit clr,
                           input bit cmt, input int busy_n, input bit abort, input bit rst_chk);
    logic [1:0] code;
    cfg_valid_i  = 1'b1;
    cfg_age_i    = age;
    cfg_word_i   = w;
    cfg_clear_i  = clr;
    cfg_commit_i = cmt;
    acc_busy_i   = 1'($urandom_range(0, 1));
    tick();
    if (clr) clear_shadow_valid();
    exp_ready = 1'b0;
    junk();
    if (rst_chk) begin
      do_reset();
      return;
    end
    tick();
    code = legal_code(w);
    if (code == 2'd0) begin
      m_shadow[age] = w;
    end else begin
      exp_err      = 1'b1;
      exp_err_age  = age;
      exp_err_code = code;
    end
    exp_ready = !cmt;
    idle_inputs();
    if (cmt) wait_commit(busy_n, abort);
  endtask

  task automatic commit_only(input bit clr, input int busy_n, input bit abort);
    cfg_valid_i  = 1'b0;
    cfg_clear_i  = clr;
    cfg_commit_i = 1'b1;
    tick();
    if (clr) clear_shadow_valid();
    exp_ready = 1'b0;
    wait_commit(busy_n, abort);
  endtask

  task automatic clear_only();
    cfg_valid_i  = 1'b0;
    cfg_clear_i  = 1'b1;
    cfg_commit_i = 1'b0;
    tick();
    clear_shadow_valid();
    idle_inputs();
  endtask

  function automatic logic [NW-1:0] rand_word();
    logic [NW-1:0] w;
    w = NW'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      w[14:12] = 3'($urandom_range(0, 4));
      w[8:6]   = 3'($urandom_range(0, 4));
      w[11]    = 1'b1;
    end
    return w;
  endfunction

  initial begin
    int op;
    int bz;
    bit ab;

    rst_i = 1'b1;
    model_reset();
    idle_inputs();
    run = 1'b1;
    tick();
    tick();
    chk("reset_ready", cfg_ready_o, 1'b1);
    chk("reset_active_valid", active_valid_o, 8'h00);
    chk("reset_err", err_o, 1'b0);
    rst_i = 1'b0;
    idle_inputs();
    tick();

    // Legal write then commit.
    send_word(3'd3, 25'h1102A95, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    commit_only(1'b0, 0, 1'b0);
    chk("legal_entry3", active_cfg_o[3*NW +: NW], 25'h1102A95);
    chk("legal_valid_bits", active_valid_o, 8'h08);
    chk("legal_done_pulse", commit_done_o, 1'b1);
    tick();
    chk("legal_done_end", commit_done_o, 1'b0);

    // Bank overflow.
    send_word(3'd5, 25'h10001D0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("ovf_err", err_o, 1'b1);
    chk("ovf_code", err_code_o, 2'b10);
    chk("ovf_age", err_age_o, 3'd5);
    commit_only(1'b0, 0, 1'b0);
    chk("ovf_entry5", active_cfg_o[5*NW +: NW], 25'h0);

    // Constraint error.
    send_word(3'd6, 25'h1005000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("iv_code", err_code_o, 2'b01);
    chk("iv_age", err_age_o, 3'd6);

    // Busy hold for 10 cycles.
    send_word(3'd1, 25'h1000010, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    commit_only(1'b0, 10, 1'b0);
    chk("busy_entry1", active_cfg_o[1*NW +: NW], 25'h1000010);

    // Word and commit in the same cycle.
    send_word(3'd2, 25'h1000020, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    chk("vc_entry2", active_cfg_o[2*NW +: NW], 25'h1000020);

    // Clear plus commit.
    commit_only(1'b1, 0, 1'b0);
    chk("clr_commit_valid", active_valid_o, 8'h00);

    // Reset while waiting on the accelerator.
    send_word(3'd4, 25'h1000840, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    commit_only(1'b0, 5, 1'b1);
    chk("abort_valid", active_valid_o, 8'h00);
    chk("abort_ready", cfg_ready_o, 1'b1);
    chk("abort_done", commit_done_o, 1'b0);

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      bz = $urandom_range(0, 3);
      ab = ($urandom_range(0, 19) == 0);
      if (op < 6) begin
        send_word(3'($urandom), rand_word(), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), bz, ab, ($urandom_range(0, 39) == 0));
      end else if (op < 8) begin
        commit_only(($urandom_range(0, 3) == 0), bz, ab);
      end else if (op == 8) begin
        clear_only();
      end else begin
        idle_inputs();
        tick();
      end
    end

    idle_inputs();
    tick();
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
